// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the 5-stage RV32 pipeline.
//
// Applies operand forwarding, evaluates the single-cycle ALU or an iterative
// shift-add MUL, resolves branch/jump redirects, and drives the EX/MEM register.
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   RegWriteE..ALUSrcE            ID/EX control bits
//   ALUControlE                   ALU operation select
//   RD1E, RD2E, ImmExtE           ID/EX operands
//   PCE, PCplus4E, RdE            ID/EX PC values and destination register
//   ForwardAE, ForwardBE          forward selects (00 regfile, 01 ResultW, 10 ALUresultM)
//   ResultW                       writeback result for forwarding
//   PCSrcE, PCTargetE             combinational fetch redirect and target
//   BusyE                         combinational stall request while a MUL runs
//   RegWriteM..RdM                registered EX/MEM outputs
module execute_cycle #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_STEPS  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RegWriteE,
  input  logic                  ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  JumpE,
  input  logic                  BranchE,
  input  logic                  ALUSrcE,
  input  logic [3:0]            ALUControlE,
  input  logic [DATA_WIDTH-1:0] RD1E,
  input  logic [DATA_WIDTH-1:0] RD2E,
  input  logic [DATA_WIDTH-1:0] ImmExtE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCplus4E,
  input  logic [4:0]            RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [DATA_WIDTH-1:0] ResultW,
  output logic                  PCSrcE,
  output logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  BusyE,
  output logic                  RegWriteM,
  output logic                  ResultSrcM,
  output logic                  MemwriteM,
  output logic [DATA_WIDTH-1:0] ALUresultM,
  output logic [DATA_WIDTH-1:0] WriteDataM,
  output logic [DATA_WIDTH-1:0] PCplus4M,
  output logic [4:0]            RdM
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSlt  = 4'b0101;
  localparam logic [3:0] OpSll  = 4'b0110;
  localparam logic [3:0] OpSrl  = 4'b0111;
  localparam logic [3:0] OpSra  = 4'b1000;
  localparam logic [3:0] OpSltu = 4'b1001;
  localparam logic [3:0] OpMul  = 4'b1010;

  localparam int unsigned CntW = $clog2(MUL_STEPS + 1);
  localparam int unsigned ShW  = $clog2(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(MUL_STEPS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t                  state;
  logic [CntW-1:0]         cnt;
  logic [DATA_WIDTH-1:0]   acc;
  logic [DATA_WIDTH-1:0]   mcand;
  logic [DATA_WIDTH-1:0]   mplier;

  logic [DATA_WIDTH-1:0]   src_a;
  logic [DATA_WIDTH-1:0]   src_b;
  logic [DATA_WIDTH-1:0]   write_data_e;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic [ShW-1:0]          shamt;
  logic                    is_mul;
  logic                    zero_e;

  // EX/MEM next-state values
  logic                    reg_write_d;
  logic                    result_src_d;
  logic                    mem_write_d;
  logic [DATA_WIDTH-1:0]   alu_result_d;
  logic [DATA_WIDTH-1:0]   write_data_d;
  logic [DATA_WIDTH-1:0]   pc_plus4_d;
  logic [4:0]              rd_d;

  assign is_mul = (ALUControlE == OpMul);
  assign shamt  = src_b[ShW-1:0];

  // Forwarding muxes; select 11 falls back to the register file value.
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUresultM;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUresultM;
      default: write_data_e = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : write_data_e;
  end

  // Single-cycle ALU; MUL is handled by the iterative datapath and yields 0 here.
  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      OpAdd:   alu_result = src_a + src_b;
      OpSub:   alu_result = src_a - src_b;
      OpAnd:   alu_result = src_a & src_b;
      OpOr:    alu_result = src_a | src_b;
      OpXor:   alu_result = src_a ^ src_b;
      OpSlt:   alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OpSltu:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a < src_b)};
      OpSll:   alu_result = src_a << shamt;
      OpSrl:   alu_result = src_a >> shamt;
      OpSra:   alu_result = $unsigned($signed(src_a) >>> shamt);
      default: alu_result = '0;
    endcase
  end

  // A MUL never reports zero so it cannot be mistaken for a taken branch.
  assign zero_e    = (alu_result == '0) && !is_mul;
  assign PCSrcE    = JumpE | (BranchE & zero_e);
  assign PCTargetE = PCE + ImmExtE;
  assign BusyE     = ((state == StIdle) && is_mul) || (state == StRun);

  // EX/MEM load selection: ALU result, bubble, or finished product.
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 1'b0;
    mem_write_d  = 1'b0;
    alu_result_d = '0;
    write_data_d = '0;
    pc_plus4_d   = '0;
    rd_d         = '0;
    case (state)
      StIdle: begin
        if (!is_mul) begin
          reg_write_d  = RegWriteE;
          result_src_d = ResultSrcE;
          mem_write_d  = MemWriteE;
          alu_result_d = alu_result;
          write_data_d = write_data_e;
          pc_plus4_d   = PCplus4E;
          rd_d         = RdE;
        end
      end
      StDone: begin
        reg_write_d  = RegWriteE;
        result_src_d = ResultSrcE;
        mem_write_d  = MemWriteE;
        alu_result_d = acc;
        write_data_d = write_data_e;
        pc_plus4_d   = PCplus4E;
        rd_d         = RdE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= StIdle;
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemwriteM  <= 1'b0;
      ALUresultM <= '0;
      WriteDataM <= '0;
      PCplus4M   <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= reg_write_d;
      ResultSrcM <= result_src_d;
      MemwriteM  <= mem_write_d;
      ALUresultM <= alu_result_d;
      WriteDataM <= write_data_d;
      PCplus4M   <= pc_plus4_d;
      RdM        <= rd_d;
      case (state)
        StIdle: begin
          if (is_mul) begin
            // Operands are captured once; later forwarding changes are ignored.
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= StRun;
          end
        end
        StRun: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LastCnt) begin
            state <= StDone;
          end
        end
        StDone: begin
          // ID/EX advances on this edge, so returning to idle cannot restart this MUL.
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
module tb_execute_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [3:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        BusyE;
  logic        RegWriteM, ResultSrcM, MemwriteM;
  logic [31:0] ALUresultM, WriteDataM, PCplus4M;
  logic [4:0]  RdM;

  execute_cycle dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteE  (RegWriteE),
    .ResultSrcE (ResultSrcE),
    .MemWriteE  (MemWriteE),
    .JumpE      (JumpE),
    .BranchE    (BranchE),
    .ALUSrcE    (ALUSrcE),
    .ALUControlE(ALUControlE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .ImmExtE    (ImmExtE),
    .PCE        (PCE),
    .PCplus4E   (PCplus4E),
    .RdE        (RdE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .ResultW    (ResultW),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .BusyE      (BusyE),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemwriteM  (MemwriteM),
    .ALUresultM (ALUresultM),
    .WriteDataM (WriteDataM),
    .PCplus4M   (PCplus4M),
    .RdM        (RdM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic        rs;
    logic        mw;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] pc4      = 32'h0000_0104;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every EX/MEM entry with RegWriteM set is a retired instruction.
  always @(negedge clk) begin
    if (rst && RegWriteM) begin
      exp_t e;
      exp_t a;
      a = '{res: ALUresultM, rd: RdM, wd: WriteDataM, pc4: PCplus4M,
            rs: ResultSrcM, mw: MemwriteM};
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL exmem_unexpected actual res=%h rd=%0d required none", ALUresultM, RdM);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL exmem actual res=%h rd=%0d wd=%h pc4=%h rs=%b mw=%b required res=%h rd=%0d wd=%h pc4=%h rs=%b mw=%b",
                   a.res, a.rd, a.wd, a.pc4, a.rs, a.mw, e.res, e.rd, e.wd, e.pc4, e.rs, e.mw);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ALUControlE = 4'b0000; RD1E = 0; RD2E = 0; ImmExtE = 0; PCE = 0; PCplus4E = 0;
    RdE = 0; ForwardAE = 0; ForwardBE = 0;
  endtask

  // Issue one single-cycle op for one cycle and queue its EX/MEM image.
  task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] fa, input logic [1:0] fb, input logic alusrc,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic [31:0] exp_wd,
                        input logic rs, input logic mw);
    ALUControlE = op; RD1E = a; RD2E = b; ForwardAE = fa; ForwardBE = fb;
    ALUSrcE = alusrc; ImmExtE = imm; RdE = rd; RegWriteE = 1; ResultSrcE = rs;
    MemWriteE = mw; JumpE = 0; BranchE = 0; PCplus4E = pc4;
    sb_q.push_back('{res: exp_res, rd: rd, wd: exp_wd, pc4: pc4, rs: rs, mw: mw});
    pc4 = pc4 + 4;
    @(posedge clk);
    #1;
  endtask

  // Issue a MUL and hold it until BusyE drops (DONE cycle); returns busy cycles.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp_res, output int busy);
    ALUControlE = 4'b1010; RD1E = a; RD2E = b; ForwardAE = 0; ForwardBE = 0; ALUSrcE = 0;
    ImmExtE = 0; RdE = rd; RegWriteE = 1; ResultSrcE = 0; MemWriteE = 0;
    JumpE = 0; BranchE = 0; PCplus4E = pc4;
    sb_q.push_back('{res: exp_res, rd: rd, wd: b, pc4: pc4, rs: 1'b0, mw: 1'b0});
    pc4 = pc4 + 4;
    busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!BusyE) break;
      busy++;
      if (busy == 5) chk("mul_bubble_regwrite", {31'b0, RegWriteM}, 32'd0);
      if (busy == 6) chk("mul_bubble_rd", {27'b0, RdM}, 32'd0);
      // Disturb forwarding inputs while running; the product must not change.
      if (busy >= 2) begin
        ResultW   = $urandom;
        ForwardAE = 2'(busy % 3);
      end
    end
    ForwardAE = 0;
  endtask

  initial begin
    int busy;
    rst = 0;
    ResultW = 0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_regwrite", {31'b0, RegWriteM}, 32'd0);
    chk("reset_aluresult", ALUresultM, 32'd0);
    chk("reset_busy", {31'b0, BusyE}, 32'd0);
    rst = 1;

    // Single-cycle ALU ops
    alu_op(4'b0000, 32'd5, 32'd7, 2'b00, 2'b00, 0, 0, 5'd3, 32'd12, 32'd7, 0, 0);
    ResultW = 32'd20;
    alu_op(4'b0001, 32'd111, 32'd222, 2'b10, 2'b01, 0, 0, 5'd4, 32'hFFFF_FFF8, 32'd20, 0, 0);
    alu_op(4'b0001, 32'd30, 32'd10, 2'b11, 2'b11, 0, 0, 5'd5, 32'd20, 32'd10, 0, 0);
    alu_op(4'b0010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 5'd6, 32'h00F0_00F0, 32'h0FF0_0FF0, 0, 0);
    alu_op(4'b0011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 5'd7, 32'hFFF0_FFF0, 32'h0FF0_0FF0, 0, 0);
    alu_op(4'b0100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0, 5'd8, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0);
    alu_op(4'b0101, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 5'd9, 32'd1, 32'd1, 0, 0);
    alu_op(4'b1001, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 5'd10, 32'd0, 32'd1, 0, 0);
    alu_op(4'b1001, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 0, 5'd11, 32'd1, 32'hFFFF_FFFF, 0, 0);
    alu_op(4'b0110, 32'd1, 32'h55, 0, 0, 1, 32'd4, 5'd12, 32'h10, 32'h55, 0, 0);
    alu_op(4'b0110, 32'd3, 32'h24, 0, 0, 0, 0, 5'd13, 32'h30, 32'h24, 0, 0);
    alu_op(4'b0111, 32'h8000_0000, 32'd0, 0, 0, 1, 32'd4, 5'd14, 32'h0800_0000, 32'd0, 0, 0);
    alu_op(4'b1000, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 5'd15, 32'hF800_0000, 32'd4, 0, 0);
    alu_op(4'b0000, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0, 5'd16, 32'd1, 32'd2, 1, 1);
    alu_op(4'b1111, 32'd5, 32'd7, 0, 0, 0, 0, 5'd17, 32'd0, 32'd7, 0, 0);
    alu_op(4'b1011, 32'd5, 32'd7, 0, 0, 0, 0, 5'd18, 32'd0, 32'd7, 0, 0);
    idle();

    // Branch / jump resolution is combinational
    BranchE = 1; ALUControlE = 4'b0001; RD1E = 32'd9; RD2E = 32'd9;
    PCE = 32'h100; ImmExtE = 32'hFFFF_FFF0;
    #1;
    chk("branch_taken", {31'b0, PCSrcE}, 32'd1);
    chk("branch_target", PCTargetE, 32'h0000_00F0);
    RD2E = 32'd8;
    #1;
    chk("branch_not_taken", {31'b0, PCSrcE}, 32'd0);
    BranchE = 0; JumpE = 1;
    #1;
    chk("jump_taken", {31'b0, PCSrcE}, 32'd1);
    idle();
    @(posedge clk);
    #1;

    // MUL: 0xFFFFFFFF * 3
    run_mul(32'hFFFF_FFFF, 32'd3, 5'd9, 32'hFFFF_FFFD, busy);
    chk("mul_busy_cycles", busy, 32'd33);
    @(posedge clk);
    #1;
    idle();
    @(posedge clk);
    #1;

    // Reset during RUN with count = 10
    ALUControlE = 4'b1010; RD1E = 32'd6; RD2E = 32'd7; RdE = 5'd20; RegWriteE = 1;
    PCplus4E = 32'h400;
    repeat (11) @(posedge clk);
    #1;
    chk("mid_mul_busy_before_reset", {31'b0, BusyE}, 32'd1);
    rst = 0;
    idle();
    @(posedge clk);
    #1;
    chk("mid_reset_busy", {31'b0, BusyE}, 32'd0);
    chk("mid_reset_regwrite", {31'b0, RegWriteM}, 32'd0);
    chk("mid_reset_aluresult", ALUresultM, 32'd0);
    chk("mid_reset_rd", {27'b0, RdM}, 32'd0);
    chk("mid_reset_pc4", PCplus4M, 32'd0);
    rst = 1;
    alu_op(4'b0000, 32'd100, 32'd23, 0, 0, 0, 0, 5'd21, 32'd123, 32'd23, 0, 0);
    idle();
    @(posedge clk);
    #1;

    // Back-to-back MULs
    run_mul(32'd6, 32'd7, 5'd10, 32'd42, busy);
    chk("b2b_first_busy", busy, 32'd33);
    @(posedge clk);
    #1;
    run_mul(32'h0001_0000, 32'h0001_0000, 5'd11, 32'd0, busy);
    chk("b2b_second_busy", busy, 32'd33);
    @(posedge clk);
    #1;
    idle();
    repeat (3) @(negedge clk);
    chk("no_third_start", {31'b0, BusyE}, 32'd0);
    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
